// File: rtl/instr_fetch.sv
// Instruction fetch unit: a two-state request/hold FSM that fetches one word, presents it
// to decode, and picks the next PC (jump, taken beq or sequential) at the decode handoff.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h00000000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        jump,
    input  logic        branch,
    input  logic        zero,
    input  logic [15:0] branch_offset,
    input  logic [25:0] jump_target
);

    typedef enum logic {StReq, StHold} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_out_q, pc_out_d;
    logic [31:0] branch_disp;
    logic [31:0] next_pc;

    assign imem_addr   = {pc_q[31:2], 2'b00};
    assign instr       = instr_q;
    assign opcode      = instr_q[31:26];
    assign pc_out      = pc_out_q;
    assign pc_plus4    = pc_out_q + 32'd4;
    assign branch_disp = {{14{branch_offset[15]}}, branch_offset, 2'b00};

    // Jump wins over branch when both are asserted.
    always_comb begin
        next_pc = pc_plus4;
        if (jump) begin
            next_pc = {pc_plus4[31:28], jump_target, 2'b00};
        end else if (branch && zero) begin
            next_pc = pc_plus4 + branch_disp;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        instr_d     = instr_q;
        pc_out_d    = pc_out_q;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        unique case (state_q)
            StReq: begin
                // Gated by reset so an in-flight request is withdrawn without waiting for a clock.
                imem_req = ~reset;
                if (imem_ack) begin
                    instr_d  = imem_rdata;
                    pc_out_d = pc_q;
                    state_d  = StHold;
                end
            end
            StHold: begin
                instr_valid = 1'b1;
                if (instr_ready) begin
                    pc_d    = {next_pc[31:2], 2'b00};
                    state_d = StReq;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StReq;
            pc_q     <= {RESET_PC[31:2], 2'b00};
            instr_q  <= 32'd0;
            pc_out_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            pc_out_q <= pc_out_d;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a memory responder pushes each returned word onto a
// scoreboard that is popped and compared when decode sees instr_valid.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
    logic        instr_valid;
    logic        instr_ready;
    logic        jump;
    logic        branch;
    logic        zero;
    logic [15:0] branch_offset;
    logic [25:0] jump_target;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   checks = 0;
    int   errors = 0;

    instr_fetch #(.RESET_PC(32'h00000000)) dut (
        .clk           (clk),
        .reset         (reset),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .instr         (instr),
        .opcode        (opcode),
        .pc_out        (pc_out),
        .pc_plus4      (pc_plus4),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .jump          (jump),
        .branch        (branch),
        .zero          (zero),
        .branch_offset (branch_offset),
        .jump_target   (jump_target)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Hold off the ack for 'waits' cycles, then return 'data'; check the presented result.
    task automatic fetch(input int waits, input logic [31:0] addr, input logic [31:0] data);
        repeat (waits) begin
            @(negedge clk);
            chk("wait_req", {31'd0, imem_req}, 32'd1);
            chk("wait_addr", imem_addr, addr);
            chk("wait_valid", {31'd0, instr_valid}, 32'd0);
        end
        @(negedge clk);
        chk("req", {31'd0, imem_req}, 32'd1);
        chk("addr", imem_addr, addr);
        chk("req_valid", {31'd0, instr_valid}, 32'd0);
        imem_ack   = 1'b1;
        imem_rdata = data;
        sb.push_back('{pc: addr, ins: data});
        @(posedge clk);
        #1 imem_ack = 1'b0;
        imem_rdata = $urandom;
        @(negedge clk);
        cur = sb.pop_front();
        chk("hold_valid", {31'd0, instr_valid}, 32'd1);
        chk("hold_req", {31'd0, imem_req}, 32'd0);
        chk("instr", instr, cur.ins);
        chk("opcode", {26'd0, opcode}, {26'd0, cur.ins[31:26]});
        chk("pc_out", pc_out, cur.pc);
        chk("pc_plus4", pc_plus4, cur.pc + 32'd4);
    endtask

    // Called at the negedge in HOLD; control inputs get noise afterwards to show they are ignored.
    task automatic handoff(input logic j, input logic b, input logic z,
                           input logic [15:0] off, input logic [25:0] tgt);
        instr_ready   = 1'b1;
        jump          = j;
        branch        = b;
        zero          = z;
        branch_offset = off;
        jump_target   = tgt;
        @(posedge clk);
        #1 instr_ready = 1'b0;
        jump          = 1'b1;
        branch        = 1'b1;
        zero          = 1'b1;
        branch_offset = 16'h1234;
        jump_target   = 26'h0155555;
    endtask

    initial begin
        reset         = 1'b1;
        imem_ack      = 1'b0;
        imem_rdata    = 32'd0;
        instr_ready   = 1'b0;
        jump          = 1'b0;
        branch        = 1'b0;
        zero          = 1'b0;
        branch_offset = 16'd0;
        jump_target   = 26'd0;
        #1;
        chk("rst_instr", instr, 32'd0);
        chk("rst_pc_out", pc_out, 32'd0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rel_req", {31'd0, imem_req}, 32'd1);
        chk("rel_addr", imem_addr, 32'h0);

        // Sequential stream, zero-wait memory: one instruction per two cycles.
        fetch(0, 32'h0, 32'h8C010000);
        handoff(1'b0, 1'b0, 1'b0, 16'd0, 26'd0);
        fetch(0, 32'h4, 32'h00221820);
        handoff(1'b0, 1'b0, 1'b0, 16'd0, 26'd0);
        fetch(0, 32'h8, 32'h10220003);
        handoff(1'b0, 1'b0, 1'b0, 16'd0, 26'd0);
        fetch(0, 32'hC, 32'hAC030004);
        handoff(1'b0, 1'b0, 1'b0, 16'd0, 26'd0);

        // Decode stall: outputs frozen while jump toggles.
        fetch(0, 32'h10, 32'h08000123);
        repeat (4) begin
            @(posedge clk);
            #1 jump = ~jump;
            @(negedge clk);
            chk("stall_valid", {31'd0, instr_valid}, 32'd1);
            chk("stall_req", {31'd0, imem_req}, 32'd0);
            chk("stall_instr", instr, cur.ins);
            chk("stall_pc_out", pc_out, cur.pc);
        end
        handoff(1'b0, 1'b0, 1'b0, 16'd0, 26'd0);

        fetch(0, 32'h14, 32'h12345678);
        handoff(1'b1, 1'b0, 1'b0, 16'd0, 26'h0000010);
        fetch(0, 32'h40, 32'h1022FFFE);
        handoff(1'b0, 1'b1, 1'b1, 16'hFFFE, 26'd0);
        fetch(0, 32'h3C, 32'h08000010);
        handoff(1'b1, 1'b0, 1'b0, 16'd0, 26'h0000010);
        fetch(0, 32'h40, 32'h1022FFFE);
        handoff(1'b0, 1'b1, 1'b0, 16'hFFFE, 26'd0);
        fetch(0, 32'h44, 32'h08000008);
        handoff(1'b1, 1'b0, 1'b0, 16'd0, 26'h0000008);

        // Reset while waiting on an ack at 0x20, with ack asserted during reset.
        repeat (2) begin
            @(negedge clk);
            chk("pre_rst_req", {31'd0, imem_req}, 32'd1);
            chk("pre_rst_addr", imem_addr, 32'h20);
        end
        #2 reset = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEADBEEF;
        #1;
        chk("mid_rst_req", {31'd0, imem_req}, 32'd0);
        chk("mid_rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("mid_rst_addr", imem_addr, 32'h0);
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_instr", instr, 32'd0);
        chk("mid_rst_pc_out", pc_out, 32'd0);
        chk("mid_rst_valid2", {31'd0, instr_valid}, 32'd0);
        reset    = 1'b0;
        imem_ack = 1'b0;
        #1;
        chk("rel2_req", {31'd0, imem_req}, 32'd1);
        chk("rel2_addr", imem_addr, 32'h0);
        chk("rel2_valid", {31'd0, instr_valid}, 32'd0);

        // Ack delayed 5 cycles at the reset address.
        fetch(5, 32'h0, 32'h1000FFFE);
        // Backward branch from 0 wraps below zero.
        handoff(1'b0, 1'b1, 1'b1, 16'hFFFE, 26'd0);
        fetch(0, 32'hFFFFFFFC, 32'h0BFFFFFF);
        chk("wrap_plus4", pc_plus4, 32'h00000000);
        handoff(1'b1, 1'b0, 1'b0, 16'd0, 26'h3FFFFFF);
        fetch(0, 32'h0FFFFFFC, 32'h10000010);
        handoff(1'b0, 1'b1, 1'b1, 16'h0010, 26'd0);
        fetch(0, 32'h10000040, 32'h08000010);
        // Jump and branch together resolve to the jump target.
        handoff(1'b1, 1'b1, 1'b1, 16'h0100, 26'h0000010);
        fetch(1, 32'h10000040, 32'hFC000000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
